// File: rtl/jk_bank_d_writer.sv
// jk_bank_d_writer
//   Register bank of WIDTH JK flip-flops written with D-style data over a
//   valid/ready handshake. Each write walks IDLE -> EXCITE -> APPLY -> CHECK:
//   the J/K excitation is computed from the current bank state and the target,
//   applied to the bank, and the result is compared against the target.
//
//   Parameters:
//     WIDTH      number of JK flip-flops (1..32)
//     DC_POLICY  0: don't-cares resolved to 0 (J = d & ~q, K = ~d & q)
//                1: don't-cares resolved to 1 (J = d | q,  K = ~(d & q))
//
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     wr_valid      write request present
//     wr_data       target value, sampled only on the transfer edge
//     wr_ready      high in IDLE only
//     q             JK bank state
//     j_out, k_out  registered J/K excitation last applied
//     busy          state is not IDLE
//     done          one-cycle pulse at write completion
//     err           one-cycle pulse with done when q != target after apply
//
//   Optional feature (macro JK_BANK_STATS_EN):
//     wr_count      16-bit completed-write counter, wraps
//     toggle_count  16-bit saturating count of bits changed by APPLY
module jk_bank_d_writer #(
   parameter int WIDTH     = 8,
   parameter int DC_POLICY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef JK_BANK_STATS_EN
   ,
   output logic [15:0]      wr_count,
   output logic [15:0]      toggle_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXCITE = 2'd1,
      ST_APPLY  = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] q_reg, j_reg, k_reg, target_reg;
   logic             done_reg, err_reg;
   logic [WIDTH-1:0] j_next, k_next, q_apply;

   // Per-bit excitation and JK characteristic equation.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (DC_POLICY == 0) begin : g_dc0
            assign j_next[gi] = target_reg[gi] & ~q_reg[gi];
            assign k_next[gi] = ~target_reg[gi] & q_reg[gi];
         end else begin : g_dc1
            assign j_next[gi] = target_reg[gi] | q_reg[gi];
            assign k_next[gi] = ~(target_reg[gi] & q_reg[gi]);
         end
         assign q_apply[gi] = (j_reg[gi] & ~q_reg[gi]) | (~k_reg[gi] & q_reg[gi]);
      end
   endgenerate

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_next = state_reg;
      wr_ready   = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            wr_ready = 1'b1;
            busy     = 1'b0;
            if (wr_valid) state_next = ST_EXCITE;
         end
         ST_EXCITE: state_next = ST_APPLY;
         ST_APPLY:  state_next = ST_CHECK;
         ST_CHECK:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg      <= '0;
         j_reg      <= '0;
         k_reg      <= '0;
         target_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         // done/err are pulses: cleared every cycle unless CHECK sets them.
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE:   if (wr_valid) target_reg <= wr_data;
            ST_EXCITE: begin
               j_reg <= j_next;
               k_reg <= k_next;
            end
            ST_APPLY:  q_reg <= q_apply;
            ST_CHECK:  begin
               done_reg <= 1'b1;
               err_reg  <= (q_reg != target_reg);
            end
            default: ;
         endcase
      end
   end

   assign q     = q_reg;
   assign j_out = j_reg;
   assign k_out = k_reg;
   assign done  = done_reg;
   assign err   = err_reg;

`ifdef JK_BANK_STATS_EN
   logic [15:0] wr_count_reg, toggle_count_reg;
   logic [15:0] flip_bits;
   logic [16:0] toggle_sum;

   // Number of bits APPLY will change: every mismatch between q and target.
   always_comb begin
      flip_bits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         flip_bits = flip_bits + 16'(q_reg[i] ^ target_reg[i]);
      end
      toggle_sum = {1'b0, toggle_count_reg} + {1'b0, flip_bits};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_reg     <= '0;
         toggle_count_reg <= '0;
      end else begin
         if (state_reg == ST_EXCITE)
            toggle_count_reg <= toggle_sum[16] ? 16'hFFFF : toggle_sum[15:0];
         // Counted on the same edge that raises done.
         if (state_reg == ST_CHECK)
            wr_count_reg <= wr_count_reg + 16'd1;
      end
   end

   assign wr_count     = wr_count_reg;
   assign toggle_count = toggle_count_reg;
`endif

endmodule

// File: tb/tb_jk_bank_d_writer.sv
// Testbench for jk_bank_d_writer: one instance per DC_POLICY, a table of
// directed writes with hand-computed J/K/q, plus hand-written sequences for a
// held wr_valid and a reset asserted during APPLY.
module tb_jk_bank_d_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid0 = 1'b0, wr_valid1 = 1'b0;
   logic [7:0] wr_data0 = '0, wr_data1 = '0;
   logic       wr_ready0, wr_ready1, busy0, busy1, done0, done1, err0, err1;
   logic [7:0] q0, q1, j0, j1, k0, k1;
`ifdef JK_BANK_STATS_EN
   logic [15:0] wrc0, wrc1, tog0, tog1;
`endif

   always #5 clk = ~clk;

   jk_bank_d_writer #(.WIDTH(8), .DC_POLICY(0)) dut0 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid0), .wr_data(wr_data0),
      .wr_ready(wr_ready0), .q(q0), .j_out(j0), .k_out(k0),
      .busy(busy0), .done(done0), .err(err0)
`ifdef JK_BANK_STATS_EN
      , .wr_count(wrc0), .toggle_count(tog0)
`endif
   );

   jk_bank_d_writer #(.WIDTH(8), .DC_POLICY(1)) dut1 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid1), .wr_data(wr_data1),
      .wr_ready(wr_ready1), .q(q1), .j_out(j1), .k_out(k1),
      .busy(busy1), .done(done1), .err(err1)
`ifdef JK_BANK_STATS_EN
      , .wr_count(wrc1), .toggle_count(tog1)
`endif
   );

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Sampled view of the selected instance.
   logic [7:0]  s_q, s_j, s_k;
   logic        s_ready, s_busy, s_done, s_err;
   logic [15:0] s_wrc, s_tog;

   task automatic sample(input int pol);
      s_q = pol ? q1 : q0;  s_j = pol ? j1 : j0;  s_k = pol ? k1 : k0;
      s_ready = pol ? wr_ready1 : wr_ready0;
      s_busy  = pol ? busy1 : busy0;
      s_done  = pol ? done1 : done0;
      s_err   = pol ? err1 : err0;
`ifdef JK_BANK_STATS_EN
      s_wrc = pol ? wrc1 : wrc0;
      s_tog = pol ? tog1 : tog0;
`else
      s_wrc = '0;
      s_tog = '0;
`endif
   endtask

   task automatic drive(input int pol, input logic v, input logic [7:0] d);
      if (pol != 0) begin wr_valid1 = v; wr_data1 = d; end
      else          begin wr_valid0 = v; wr_data0 = d; end
   endtask

   typedef struct {
      int          pol;
      logic [7:0]  data;
      logic [7:0]  exp_j;
      logic [7:0]  exp_k;
      logic [7:0]  exp_q;
      logic [15:0] exp_tog;
      logic [15:0] exp_wrc;
   } vec_t;

   // Full write, called at a falling edge with the instance idle; returns at
   // the falling edge after N+3 so the next write can transfer on N+4.
   task automatic do_write(input vec_t v);
      sample(v.pol);
      check("ready_before", 32'(s_ready), 32'd1);
      drive(v.pol, 1'b1, v.data);
      @(posedge clk); @(negedge clk);                  // after N
      drive(v.pol, 1'b0, 8'h00);
      sample(v.pol);
      check("busy_after_N", 32'(s_busy), 32'd1);
      check("ready_after_N", 32'(s_ready), 32'd0);
      @(posedge clk); @(negedge clk);                  // after N+1
      sample(v.pol);
      check("j_out", 32'(s_j), 32'(v.exp_j));
      check("k_out", 32'(s_k), 32'(v.exp_k));
      @(posedge clk); @(negedge clk);                  // after N+2
      sample(v.pol);
      check("q_after_apply", 32'(s_q), 32'(v.exp_q));
      check("done_early", 32'(s_done), 32'd0);
      @(posedge clk); @(negedge clk);                  // after N+3
      sample(v.pol);
      check("done", 32'(s_done), 32'd1);
      check("err", 32'(s_err), 32'd0);
      check("ready_after_N3", 32'(s_ready), 32'd1);
`ifdef JK_BANK_STATS_EN
      check("toggle_count", 32'(s_tog), 32'(v.exp_tog));
      check("wr_count", 32'(s_wrc), 32'(v.exp_wrc));
`endif
      $display("write pol=%0d data=%h j=%h k=%h q=%h done=%b err=%b",
               v.pol, v.data, s_j, s_k, s_q, s_done, s_err);
   endtask

   vec_t vecs[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      //          pol data   J      K      q      tog  wrc
      vecs[0] = '{0, 8'hA5, 8'hA5, 8'h00, 8'hA5, 4,   1};
      vecs[1] = '{0, 8'h5A, 8'h5A, 8'hA5, 8'h5A, 12,  2};
      vecs[2] = '{0, 8'h5A, 8'h00, 8'h00, 8'h5A, 12,  3};
      vecs[3] = '{0, 8'h00, 8'h00, 8'h5A, 8'h00, 16,  4};
      vecs[4] = '{0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 24,  5};
      vecs[5] = '{1, 8'h0F, 8'h0F, 8'hFF, 8'h0F, 4,   1};
      vecs[6] = '{1, 8'h3C, 8'h3F, 8'hF3, 8'h3C, 8,   2};
      vecs[7] = '{1, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 8,   3};

      // Reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         sample(p);
         check("rst_q", 32'(s_q), 32'd0);
         check("rst_j", 32'(s_j), 32'd0);
         check("rst_k", 32'(s_k), 32'd0);
         check("rst_ready", 32'(s_ready), 32'd1);
         check("rst_busy", 32'(s_busy), 32'd0);
         check("rst_done", 32'(s_done), 32'd0);
      end
      $display("reset released");

      for (int i = 0; i < 8; i++) do_write(vecs[i]);

      // Held wr_valid on policy 0 (q=FF): 0x11 then 0x22.
      drive(0, 1'b1, 8'h11);
      @(posedge clk); @(negedge clk);                  // after N
      drive(0, 1'b1, 8'h22);
      for (int c = 0; c < 3; c++) begin
         sample(0);
         check("held_ready_low", 32'(s_ready), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      sample(0);                                       // after N+3
      check("held_done1", 32'(s_done), 32'd1);
      check("held_q1", 32'(s_q), 32'h11);
      @(posedge clk); @(negedge clk);                  // after N+4: second transfer
      drive(0, 1'b0, 8'h00);
      sample(0);
      check("held_busy2", 32'(s_busy), 32'd1);
      check("held_done_gap", 32'(s_done), 32'd0);
      repeat (3) begin @(posedge clk); @(negedge clk); end   // after N+7
      sample(0);
      check("held_done2", 32'(s_done), 32'd1);
      check("held_q2", 32'(s_q), 32'h22);
`ifdef JK_BANK_STATS_EN
      check("held_tog", 32'(s_tog), 32'd34);
      check("held_wrc", 32'(s_wrc), 32'd7);
`endif
      $display("held write pair q=%h", s_q);

      // Reset asserted during APPLY of a 0xFF write.
      drive(0, 1'b1, 8'hFF);
      @(posedge clk); @(negedge clk);                  // after N: EXCITE
      drive(0, 1'b0, 8'h00);
      @(posedge clk); @(negedge clk);                  // after N+1: APPLY
      rst = 1'b1;
      #1;
      sample(0);
      check("mid_rst_q", 32'(s_q), 32'd0);
      check("mid_rst_j", 32'(s_j), 32'd0);
      check("mid_rst_busy", 32'(s_busy), 32'd0);
      check("mid_rst_ready", 32'(s_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         sample(0);
         check("mid_rst_no_done", 32'(s_done), 32'd0);
         check("mid_rst_q_hold", 32'(s_q), 32'd0);
      end
      $display("reset during apply q=%h", s_q);
      do_write('{0, 8'h01, 8'h01, 8'h00, 8'h01, 1, 1});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
